// File: rtl/issue_queue_age_if.sv
// Issue queue port bundle: dispatch lanes, wakeup bus, pipe busy,
// flush (master drives) and ready/issue/count (slave drives).
interface issue_queue_age_if #(
    parameter int ENTRIES    = 16,
    parameter int DISPATCH_W = 4,
    parameter int ISSUE_W    = 3,
    parameter int WAKE_W     = 3,
    parameter int TAG_W      = 6,
    parameter int FU_W       = 4,
    parameter int PAYLOAD_W  = 64
);
    localparam int CW = $clog2(ENTRIES + 1);

    logic                          flush;
    logic [DISPATCH_W-1:0]         disp_valid;
    logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload;
    logic [DISPATCH_W*FU_W-1:0]    disp_fu;
    logic [DISPATCH_W*TAG_W-1:0]   disp_src1_tag;
    logic [DISPATCH_W*TAG_W-1:0]   disp_src2_tag;
    logic [DISPATCH_W-1:0]         disp_src1_rdy;
    logic [DISPATCH_W-1:0]         disp_src2_rdy;
    logic                          disp_ready;
    logic [WAKE_W-1:0]             wake_valid;
    logic [WAKE_W*TAG_W-1:0]       wake_tag;
    logic [ISSUE_W-1:0]            pipe_busy;
    logic [ISSUE_W-1:0]            iss_valid;
    logic [ISSUE_W*PAYLOAD_W-1:0]  iss_payload;
    logic [CW-1:0]                 count;

    modport master (
        output flush, disp_valid, disp_payload, disp_fu,
        output disp_src1_tag, disp_src2_tag,
        output disp_src1_rdy, disp_src2_rdy,
        output wake_valid, wake_tag, pipe_busy,
        input  disp_ready, iss_valid, iss_payload, count
    );

    modport slave (
        input  flush, disp_valid, disp_payload, disp_fu,
        input  disp_src1_tag, disp_src2_tag,
        input  disp_src1_rdy, disp_src2_rdy,
        input  wake_valid, wake_tag, pipe_busy,
        output disp_ready, iss_valid, iss_payload, count
    );
endinterface

// File: rtl/issue_queue_age.sv
// Age-ordered issue queue: all-or-nothing dispatch, tag wakeup, oldest-
// ready select per pipe. Ports: clock, reset (sync, high), bus (slave).
module issue_queue_age #(
    parameter int ENTRIES    = 16,
    parameter int DISPATCH_W = 4,
    parameter int ISSUE_W    = 3,
    parameter int WAKE_W     = 3,
    parameter int TAG_W      = 6,
    parameter int FU_W       = 4,
    parameter int PAYLOAD_W  = 64,
    parameter logic [ISSUE_W*FU_W-1:0] PIPE_FU_MASK = {ISSUE_W{4'b1111}}
) (
    input  logic clock,
    input  logic reset,
    issue_queue_age_if.slave bus
);
    localparam int CW = $clog2(ENTRIES + 1);
    localparam int LW = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [ENTRIES-1:0]   rdy1_q, rdy1_d;
    logic [ENTRIES-1:0]   rdy2_q, rdy2_d;
    logic [TAG_W-1:0]     tag1_q [ENTRIES];
    logic [TAG_W-1:0]     tag1_d [ENTRIES];
    logic [TAG_W-1:0]     tag2_q [ENTRIES];
    logic [TAG_W-1:0]     tag2_d [ENTRIES];
    logic [FU_W-1:0]      fu_q [ENTRIES];
    logic [FU_W-1:0]      fu_d [ENTRIES];
    logic [PAYLOAD_W-1:0] pay_q [ENTRIES];
    logic [PAYLOAD_W-1:0] pay_d [ENTRIES];
    // older_q[i][j] = 1 when entry i was written before entry j
    logic [ENTRIES-1:0]   older_q [ENTRIES];
    logic [ENTRIES-1:0]   older_d [ENTRIES];

    logic [ISSUE_W-1:0]           iss_valid_q, iss_valid_d;
    logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
    logic [CW-1:0]                count_q, count_d;

    logic               disp_ready;
    logic               accept;
    logic [ENTRIES-1:0] new_vec;
    logic [LW-1:0]      new_lane [ENTRIES];
    logic [ENTRIES-1:0] grant [ISSUE_W];
    logic [ENTRIES-1:0] granted;
    logic [ENTRIES-1:0] keep;

    function automatic logic wake_hit(
        input logic [TAG_W-1:0]        t,
        input logic [WAKE_W-1:0]       wv,
        input logic [WAKE_W*TAG_W-1:0] wt
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_W; w++) begin
            if (wv[w] && (wt[w*TAG_W +: TAG_W] == t)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Pipes select in index order; an entry taken by a lower pipe is
    // masked out for higher pipes. A busy pipe takes nothing, so the
    // entry stays visible to the pipes after it.
    always_comb begin
        logic [ENTRIES-1:0] taken;
        logic [ENTRIES-1:0] cand;
        logic               blk;
        taken = '0;
        cand  = '0;
        blk   = 1'b0;
        for (int p = 0; p < ISSUE_W; p++) begin
            grant[p] = '0;
            cand     = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cand[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i]
                        & (|(fu_q[i] & PIPE_FU_MASK[p*FU_W +: FU_W]))
                        & ~taken[i];
            end
            if (!bus.pipe_busy[p]) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    blk = 1'b0;
                    for (int j = 0; j < ENTRIES; j++) begin
                        if (cand[j] && older_q[j][i]) begin
                            blk = 1'b1;
                        end
                    end
                    grant[p][i] = cand[i] & ~blk;
                end
            end
            taken = taken | grant[p];
        end
        granted = taken;
    end

    // Valid lanes take the lowest free entries in lane order. Entries
    // freed by this cycle's grants are not visible as free until the
    // next cycle because the free map comes from registered valid.
    always_comb begin
        logic [ENTRIES-1:0] avail;
        logic               found;
        disp_ready = (CW'(ENTRIES) - count_q) >= CW'(DISPATCH_W);
        accept     = disp_ready & ~bus.flush;
        avail      = ~valid_q;
        found      = 1'b0;
        new_vec    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            new_lane[i] = '0;
        end
        for (int l = 0; l < DISPATCH_W; l++) begin
            found = 1'b0;
            if (accept && bus.disp_valid[l]) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (!found && avail[i]) begin
                        found       = 1'b1;
                        avail[i]    = 1'b0;
                        new_vec[i]  = 1'b1;
                        new_lane[i] = LW'(l);
                    end
                end
            end
        end
    end

    assign keep = valid_q & ~granted;

    always_comb begin
        int l;
        l       = 0;
        valid_d = keep | new_vec;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        for (int i = 0; i < ENTRIES; i++) begin
            tag1_d[i] = tag1_q[i];
            tag2_d[i] = tag2_q[i];
            fu_d[i]   = fu_q[i];
            pay_d[i]  = pay_q[i];
            if (new_vec[i]) begin
                l         = int'(new_lane[i]);
                tag1_d[i] = bus.disp_src1_tag[l*TAG_W +: TAG_W];
                tag2_d[i] = bus.disp_src2_tag[l*TAG_W +: TAG_W];
                fu_d[i]   = bus.disp_fu[l*FU_W +: FU_W];
                pay_d[i]  = bus.disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
                rdy1_d[i] = bus.disp_src1_rdy[l]
                          | wake_hit(tag1_d[i], bus.wake_valid, bus.wake_tag);
                rdy2_d[i] = bus.disp_src2_rdy[l]
                          | wake_hit(tag2_d[i], bus.wake_valid, bus.wake_tag);
            end else begin
                rdy1_d[i] = rdy1_q[i]
                          | wake_hit(tag1_q[i], bus.wake_valid, bus.wake_tag);
                rdy2_d[i] = rdy2_q[i]
                          | wake_hit(tag2_q[i], bus.wake_valid, bus.wake_tag);
            end
        end

        // A new entry is younger than every surviving entry; within a
        // group the lower lane is older. Stale rows of free entries are
        // harmless because selection only looks at valid candidates.
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                older_d[i][j] = older_q[i][j];
                if (new_vec[j]) begin
                    older_d[i][j] = new_vec[i] ? (new_lane[i] < new_lane[j])
                                               : keep[i];
                end else if (new_vec[i]) begin
                    older_d[i][j] = 1'b0;
                end
            end
        end

        iss_valid_d   = '0;
        iss_payload_d = iss_payload_q;
        for (int p = 0; p < ISSUE_W; p++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (grant[p][i]) begin
                    iss_valid_d[p] = 1'b1;
                    iss_payload_d[p*PAYLOAD_W +: PAYLOAD_W] = pay_q[i];
                end
            end
        end

        count_d = count_q + CW'($countones(new_vec))
                          - CW'($countones(granted));

        // Flush discards this cycle's grants, wakeups and dispatch.
        if (bus.flush) begin
            valid_d     = '0;
            iss_valid_d = '0;
            count_d     = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                older_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q       <= '0;
            rdy1_q        <= '0;
            rdy2_q        <= '0;
            iss_valid_q   <= '0;
            iss_payload_q <= '0;
            count_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            rdy1_q        <= rdy1_d;
            rdy2_q        <= rdy2_d;
            iss_valid_q   <= iss_valid_d;
            iss_payload_q <= iss_payload_d;
            count_q       <= count_d;
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    // Entry payload and tags are qualified by valid, so no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ENTRIES; i++) begin
            tag1_q[i] <= tag1_d[i];
            tag2_q[i] <= tag2_d[i];
            fu_q[i]   <= fu_d[i];
            pay_q[i]  <= pay_d[i];
        end
    end

    assign bus.disp_ready  = disp_ready;
    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_payload = iss_payload_q;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_issue_queue_age.sv
// Directed bench for issue_queue_age: a cycle table on a generic-mask
// instance plus hand sequences on an ALU/MUL/LD split-mask instance.
module tb_issue_queue_age;
    logic clock = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clock = ~clock;

    issue_queue_age_if ifa ();
    issue_queue_age_if ifb ();

    issue_queue_age dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    // pipe0 ALU only, pipe1 MUL only, pipe2 LD only
    issue_queue_age #(
        .PIPE_FU_MASK (12'h421)
    ) dut_b (
        .clock (clock),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    always @(negedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (ifa.disp_valid[l]) assert ($onehot(ifa.disp_fu[l*4 +: 4]));
            if (ifb.disp_valid[l]) assert ($onehot(ifb.disp_fu[l*4 +: 4]));
        end
    end

    typedef struct {
        logic [3:0] dv;
        logic [7:0] pb;
        logic       rdy;
        logic [5:0] tag;
        logic [2:0] wv;
        logic [5:0] wt;
        logic [2:0] busy;
        logic       fl;
        logic [4:0] cnt;
        logic       drdy;
        logic [2:0] iv;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [3:0] dv, input logic [7:0] pb,
        input logic rdy, input logic [5:0] tag,
        input logic [2:0] wv, input logic [5:0] wt,
        input logic [2:0] busy, input logic fl,
        input logic [4:0] cnt, input logic drdy,
        input logic [2:0] iv, input logic [7:0] p0,
        input logic [7:0] p1, input logic [7:0] p2
    );
        vec_t v;
        v.dv = dv; v.pb = pb; v.rdy = rdy; v.tag = tag;
        v.wv = wv; v.wt = wt; v.busy = busy; v.fl = fl;
        v.cnt = cnt; v.drdy = drdy; v.iv = iv;
        v.p0 = p0; v.p1 = p1; v.p2 = p2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        ifa.flush      = v.fl;
        ifa.disp_valid = v.dv;
        for (int l = 0; l < 4; l++) begin
            ifa.disp_payload[l*64 +: 64] = 64'(v.pb + 8'(l));
            ifa.disp_fu[l*4 +: 4]        = 4'b0001;
            ifa.disp_src1_tag[l*6 +: 6]  = v.tag;
            ifa.disp_src2_tag[l*6 +: 6]  = 6'd0;
            ifa.disp_src1_rdy[l]         = v.rdy;
            ifa.disp_src2_rdy[l]         = 1'b1;
        end
        ifa.wake_valid = v.wv;
        ifa.wake_tag   = {3{v.wt}};
        ifa.pipe_busy  = v.busy;
    endtask

    task automatic b_idle();
        ifb.flush         = 1'b0;
        ifb.disp_valid    = '0;
        ifb.disp_payload  = '0;
        ifb.disp_fu       = {4{4'b0001}};
        ifb.disp_src1_tag = '0;
        ifb.disp_src2_tag = '0;
        ifb.disp_src1_rdy = '0;
        ifb.disp_src2_rdy = '0;
        ifb.wake_valid    = '0;
        ifb.wake_tag      = '0;
        ifb.pipe_busy     = '0;
    endtask

    task automatic b_uop(input logic [7:0] pay, input logic [3:0] fu,
                         input logic [5:0] t1, input logic r1,
                         input logic [5:0] t2, input logic r2);
        b_idle();
        ifb.disp_valid[0]        = 1'b1;
        ifb.disp_payload[63:0]   = 64'(pay);
        ifb.disp_fu[3:0]         = fu;
        ifb.disp_src1_tag[5:0]   = t1;
        ifb.disp_src1_rdy[0]     = r1;
        ifb.disp_src2_tag[5:0]   = t2;
        ifb.disp_src2_rdy[0]     = r2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_b(input string nm, input logic [4:0] cnt,
                         input logic [2:0] iv);
        chk({nm, " b count"}, 192'(ifb.count), 192'(cnt));
        chk({nm, " b iss_valid"}, 192'(ifb.iss_valid), 192'(iv));
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        logic [7:0] ep [3];
        idle = mk(4'h0, 8'h00, 1'b0, 6'd0, 3'b000, 6'd0, 3'b000, 1'b0,
                  5'd0, 1'b1, 3'b000, 8'h00, 8'h00, 8'h00);

        // Test 2: four ready ALU uops
        tbl.push_back(mk(4'hF, 8'hA0, 1, 0, 0, 0, 0, 0, 4, 1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 3'b111,
                         8'hA0, 8'hA1, 8'hA2));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001,
                         8'hA3, 0, 0));
        tbl.push_back(idle);
        // Test 4: fill 13 waiting on tag 7, dropped group, wake, drain
        tbl.push_back(mk(4'hF, 8'h10, 0, 7, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'hF, 8'h14, 0, 7, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'hF, 8'h18, 0, 7, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'h1, 8'h1C, 0, 7, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'hF, 8'h30, 1, 0, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 3'b001, 7, 0, 0, 13, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 10, 1, 3'b111,
                         8'h10, 8'h11, 8'h12));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 7, 1, 3'b111,
                         8'h13, 8'h14, 8'h15));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 4, 1, 3'b111,
                         8'h16, 8'h17, 8'h18));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1, 3'b111,
                         8'h19, 8'h1A, 8'h1B));
        tbl.push_back(mk(4'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001,
                         8'h1C, 0, 0));
        tbl.push_back(idle);
        // Test 6: 6 entries held by busy pipes, then flush with
        // dispatch, wake and grants in the same cycle
        tbl.push_back(mk(4'hF, 8'h40, 1, 0, 0, 0, 3'b111, 0, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'h3, 8'h44, 0, 20, 0, 0, 3'b111, 0, 6, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'h3, 8'h50, 1, 0, 3'b001, 20, 3'b000, 1,
                         0, 1, 0, 0, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(idle);

        // Test 1: reset
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(idle);
        b_idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst a count", 192'(ifa.count), 192'(0));
        chk("rst a disp_ready", 192'(ifa.disp_ready), 192'(1));
        chk("rst a iss_valid", 192'(ifa.iss_valid), 192'(0));
        chk("rst a iss_payload", ifa.iss_payload, 192'(0));
        chk("rst b count", 192'(ifb.count), 192'(0));
        chk("rst b disp_ready", 192'(ifb.disp_ready), 192'(1));
        chk("rst b iss_valid", 192'(ifb.iss_valid), 192'(0));
        chk("rst b iss_payload", ifb.iss_payload, 192'(0));
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            drive_a(v);
            tick();
            chk($sformatf("row%0d count", r), 192'(ifa.count), 192'(v.cnt));
            chk($sformatf("row%0d disp_ready", r),
                192'(ifa.disp_ready), 192'(v.drdy));
            chk($sformatf("row%0d iss_valid", r),
                192'(ifa.iss_valid), 192'(v.iv));
            ep[0] = v.p0;
            ep[1] = v.p1;
            ep[2] = v.p2;
            for (int p = 0; p < 3; p++) begin
                if (v.iv[p]) begin
                    chk($sformatf("row%0d payload%0d", r, p),
                        192'(ifa.iss_payload[p*64 +: 64]), 192'(ep[p]));
                end
            end
        end

        // Reset mid-operation, with a dispatch in the reset cycle
        drive_a(mk(4'h3, 8'h60, 1, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("midrst pre count", 192'(ifa.count), 192'(2));
        rst_a = 1'b1;
        drive_a(mk(4'hF, 8'h70, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        tick();
        rst_a = 1'b0;
        drive_a(idle);
        chk("midrst count", 192'(ifa.count), 192'(0));
        chk("midrst disp_ready", 192'(ifa.disp_ready), 192'(1));
        chk("midrst iss_valid", 192'(ifa.iss_valid), 192'(0));
        chk("midrst iss_payload", ifa.iss_payload, 192'(0));
        tick();
        chk("midrst after iss_valid", 192'(ifa.iss_valid), 192'(0));
        chk("midrst after count", 192'(ifa.count), 192'(0));

        // Test 3: X waits on tag 5; Y dispatches with a same-cycle
        // wake of its src2; only pipe0 takes ALU, X goes first
        b_uop(8'hB0, 4'b0001, 6'd5, 1'b0, 6'd0, 1'b1);
        tick();
        chk_b("age x", 5'd1, 3'b000);
        b_uop(8'hB1, 4'b0001, 6'd0, 1'b1, 6'd5, 1'b0);
        ifb.wake_valid      = 3'b001;
        ifb.wake_tag[5:0]   = 6'd5;
        tick();
        chk_b("age y", 5'd2, 3'b000);
        b_idle();
        tick();
        chk_b("age issue x", 5'd1, 3'b001);
        chk("age payload x", 192'(ifb.iss_payload[63:0]), 192'(8'hB0));
        tick();
        chk_b("age issue y", 5'd0, 3'b001);
        chk("age payload y", 192'(ifb.iss_payload[63:0]), 192'(8'hB1));
        tick();
        chk_b("age idle", 5'd0, 3'b000);

        // Test 5: MUL uop only fits pipe1, which is busy for 3 cycles
        b_uop(8'hC5, 4'b0010, 6'd0, 1'b1, 6'd0, 1'b1);
        ifb.pipe_busy = 3'b010;
        tick();
        chk_b("busy disp", 5'd1, 3'b000);
        ifb.disp_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_b($sformatf("busy cyc%0d", k), 5'd1, 3'b000);
        end
        ifb.pipe_busy = 3'b000;
        tick();
        chk_b("busy release", 5'd0, 3'b010);
        chk("busy payload1", 192'(ifb.iss_payload[127:64]), 192'(8'hC5));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
